rv_run_controller: RTL and testbench
====================================

Name: rv_run_controller

Overview:
- Synthesizable run controller for the RISC-V core. It generalises the fixed reset/clock stimulus of the simulation bench into a parametrised block that works in both simulation and hardware.
- Sequences the core's active-high reset and counts cycles and retired instructions.
- Detects halt by ECALL, a stalled PC or a timeout.
- Buffers register-writeback events in a trace FIFO, drained by a valid/ready consumer such as a bench checker or a UART dumper.
- Sits between the top level and RISC_V_Processor.

Parameters:
XLEN, 64, datapath/PC width
DEPTH, 8, trace FIFO entries (power of two, >=2)
RST_CYCLES, 2, cycles core_reset stays high after entering RESET_HOLD (>=1)
HALT_STABLE, 4, consecutive unchanged-PC cycles that declare halt (>=1)
MAX_CYCLES, 1000, RUN cycles before timeout
CNT_W, 32, counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
restart  in  1  synchronous re-run request, level sampled each cycle
core_reset  out  1  active-high reset to the processor
pc  in  XLEN  processor PC_Out
instr  in  32  processor Instruction
wb_en  in  1  processor RegWrite
wb_rd  in  5  destination register
wb_data  in  XLEN  WriteData
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_rd  out  5  head rd
trace_data  out  XLEN  head data
state  out  2  00 RESET_HOLD, 01 RUN, 10 HALTED, 11 TIMEOUT
cycle_count  out  CNT_W  RUN cycles elapsed
retired_count  out  CNT_W  PC changes observed in RUN
overflow  out  1  sticky: trace entry dropped

Behaviour:
- Reset (reset=0, async):
  - state=RESET_HOLD, core_reset=1, hold counter=0.
  - Counters=0, FIFO empty, trace_valid=0, overflow=0, stable counter=0, pc_prev=0.
- RESET_HOLD:
  - core_reset=1.
  - After RST_CYCLES cycles in RESET_HOLD → RUN; core_reset drops on the same edge.
- RUN:
  - core_reset=0; cycle_count +1 per cycle.
  - pc_prev<=pc every cycle. The stable counter is not evaluated on the first RUN cycle.
  - pc!=pc_prev → retired_count +1, stable counter cleared; else stable counter +1.
- RUN exit conditions, evaluated on the current-cycle inputs, priority high→low:
  - instr==32'h00000073 (ECALL) → HALTED.
  - stable counter reaching HALT_STABLE → HALTED.
  - cycle_count==MAX_CYCLES-1 → TIMEOUT.
- HALTED / TIMEOUT:
  - core_reset=1 to freeze the core; counters freeze.
  - The FIFO still drains; the state is held until restart or reset.
- restart=1 in any state: next cycle state=RESET_HOLD, counters cleared, FIFO flushed, overflow cleared. restart overrides every RUN transition.
- Trace FIFO:
  - Push when state==RUN && wb_en && wb_rd!=0, entry {wb_rd, wb_data}. Pushes are ignored outside RUN.
  - Pop on trace_valid && trace_ready.
  - trace_valid rises the cycle after the first push; head outputs are registered.
  - Full + push + pop same cycle → both occur, no overflow.
  - Full + push, no pop → entry dropped, overflow<=1 (sticky).
  - Empty + push + ready → no same-cycle bypass.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are distinguished by the MSB.
- Counters saturate at all-ones instead of wrapping.

Decomposition:
- Shared package rv_run_pkg:
  - State encodings RESET_HOLD/RUN/HALTED/TIMEOUT.
  - ECALL constant 32'h00000073.
  - Trace entry width (5+XLEN).
- One sub-module, trace_fifo:
  - Parametrised width/depth.
  - Ports: push, pop, full, empty, din, dout.
  - Synchronous flush; async active-low reset.

Test Plan:
- Reset release with RST_CYCLES=2 → core_reset high for exactly 2 clk edges after reset rises, then state=01, cycle_count increments from 0.
- PC sequence 0,4,8,8,8,8,8 → retired_count=2 and state=10 once the stable counter reaches 4, then core_reset=1.
- instr=32'h00000073 on RUN cycle 5 → state=10 next edge, cycle_count frozen at 5; stable and timeout conditions active in the same cycle are ignored.
- MAX_CYCLES=20 with PC incrementing by 4 → state=11 after 20 RUN cycles, cycle_count=19, core_reset=1.
- 10 pushes (rd=1..10, data=rd*16) with trace_ready=0 and DEPTH=8 → overflow=1. Then ready=1 drains rd 1..8, data 0x10..0x80 in order, and trace_valid drops after the 8th pop.
- Full FIFO with simultaneous push+pop, then restart=1 mid-RUN → no overflow on the push+pop cycle; on restart FIFO empty, counters 0, state=00, core_reset=1.

Source files
------------

// File: rtl/rv_run_pkg.sv
// Shared definitions for the RISC-V run controller.
//   run_state_e : controller state encoding, also driven out as the debug state
//   ECALL_INSN  : instruction word that requests a halt
//   RD_W        : width of a writeback destination register index
//   trace_w()   : width of one trace entry {rd, data} for a given XLEN
package rv_run_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'b00,
    ST_RUN        = 2'b01,
    ST_HALTED     = 2'b10,
    ST_TIMEOUT    = 2'b11
  } run_state_e;

  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;
  localparam int          RD_W       = 5;

  function automatic int trace_w(input int xlen);
    return RD_W + xlen;
  endfunction

endpackage

// File: rtl/rv_run_controller_fifo.sv
// trace_fifo: small synchronous FIFO holding register-writeback trace entries.
// Ports:
//   clk_i, rst_ni : clock (rising edge), asynchronous active-low reset
//   flush_i       : synchronous flush, empties the FIFO on the next edge
//   push_i, din_i : write request and data
//   pop_i         : read request (advance head)
//   dout_o        : head entry, read from registered storage by registered pointer
//   full_o        : no free entry
//   empty_o       : no valid entry
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is ignored (the caller reports the drop).
module trace_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit: equal low bits with differing MSB means full.
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: nothing is read out until a pointer says it is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/rv_run_controller.sv
// rv_run_controller: run controller sitting between the top level and the
// RISC-V processor. Sequences the core reset, counts RUN cycles and retired
// instructions, detects halt (ECALL, stalled PC, timeout) and buffers register
// writebacks in a trace FIFO.
// Ports:
//   clk_i, reset_ni        : clock (rising edge), asynchronous active-low reset
//   restart_i              : synchronous re-run request, sampled every cycle
//   core_reset_o           : active-high reset to the processor
//   pc_i, instr_i          : processor PC and current instruction
//   wb_en_i, wb_rd_i, wb_data_i : register writeback event
//   trace_valid_o/trace_ready_i : trace head handshake
//   trace_rd_o, trace_data_o    : trace head entry
//   state_o                : 00 RESET_HOLD, 01 RUN, 10 HALTED, 11 TIMEOUT
//   cycle_count_o          : RUN cycles elapsed (saturating)
//   retired_count_o        : PC changes observed in RUN (saturating)
//   overflow_o             : sticky, a trace entry was dropped
// Trace handshake: an entry transfers on every rising edge where
// trace_valid_o && trace_ready_i; trace_valid_o never depends combinationally
// on trace_ready_i, and the head is stable while valid is high and not taken.
module rv_run_controller
  import rv_run_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH       = 8,
  parameter int RST_CYCLES  = 2,
  parameter int HALT_STABLE = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             restart_i,
  output logic             core_reset_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [4:0]       trace_rd_o,
  output logic [XLEN-1:0]  trace_data_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] retired_count_o,
  output logic             overflow_o
);

  localparam int TW = trace_w(XLEN);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
  logic             first_q, first_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TW-1:0]    fifo_dout;
  logic             pc_changed;

  assign push_req   = (state_q == ST_RUN) && wb_en_i && (wb_rd_i != 5'd0);
  assign fifo_pop   = !fifo_empty && trace_ready_i;
  assign fifo_push  = push_req && !restart_i;
  assign pc_changed = (pc_i != pc_prev_q);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stable_d   = stable_q;
    cycle_d    = cycle_q;
    retired_d  = retired_q;
    pc_prev_d  = pc_prev_q;
    first_d    = first_q;
    overflow_d = overflow_q;

    if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;

    case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d  = ST_RUN;
          hold_d   = '0;
          stable_d = '0;
          first_d  = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        pc_prev_d = pc_i;
        first_d   = 1'b0;
        if (pc_changed) begin
          retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
          stable_d  = '0;
        end else if (!first_q) begin
          // pc_prev is stale on the first RUN cycle, so no stall is counted.
          stable_d = stable_q + CNT_W'(1);
        end
        // Exit priority: ECALL, stalled PC, timeout. The exit cycle itself is
        // not added to cycle_count, so the count freezes at the exit cycle.
        if (instr_i == ECALL_INSN) begin
          state_d = ST_HALTED;
        end else if (stable_d == CNT_W'(HALT_STABLE)) begin
          state_d = ST_HALTED;
        end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d = ST_TIMEOUT;
        end else begin
          cycle_d = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
        end
      end
      default: ;  // HALTED / TIMEOUT hold until restart or reset
    endcase

    if (restart_i) begin
      state_d    = ST_RESET_HOLD;
      hold_d     = '0;
      stable_d   = '0;
      cycle_d    = '0;
      retired_d  = '0;
      pc_prev_d  = '0;
      first_d    = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_RESET_HOLD;
      hold_q     <= '0;
      stable_q   <= '0;
      cycle_q    <= '0;
      retired_q  <= '0;
      pc_prev_q  <= '0;
      first_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      stable_q   <= stable_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      pc_prev_q  <= pc_prev_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .flush_i (restart_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({wb_rd_i, wb_data_i}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Core is held in reset in every state except RUN; the drop coincides with
  // the edge that enters RUN.
  assign core_reset_o    = (state_q != ST_RUN);
  assign state_o         = state_q;
  assign cycle_count_o   = cycle_q;
  assign retired_count_o = retired_q;
  assign overflow_o      = overflow_q;
  assign trace_valid_o   = !fifo_empty;
  assign trace_rd_o      = fifo_dout[XLEN +: 5];
  assign trace_data_o    = fifo_dout[XLEN-1:0];

endmodule

// File: tb/tb_rv_run_controller.sv
module tb_rv_run_controller;

  logic        clk;
  logic        reset_n;
  logic        restart;
  logic        core_reset;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        trace_valid;
  logic        trace_ready;
  logic [4:0]  trace_rd;
  logic [63:0] trace_data;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
  logic        overflow;

  int checks = 0;
  int passed = 0;

  rv_run_controller #(
    .XLEN(64), .DEPTH(8), .RST_CYCLES(2), .HALT_STABLE(4), .MAX_CYCLES(20), .CNT_W(32)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .restart_i       (restart),
    .core_reset_o    (core_reset),
    .pc_i            (pc),
    .instr_i         (instr),
    .wb_en_i         (wb_en),
    .wb_rd_i         (wb_rd),
    .wb_data_i       (wb_data),
    .trace_valid_o   (trace_valid),
    .trace_ready_i   (trace_ready),
    .trace_rd_o      (trace_rd),
    .trace_data_o    (trace_data),
    .state_o         (state),
    .cycle_count_o   (cycle_count),
    .retired_count_o (retired_count),
    .overflow_o      (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Restart, then wait out RESET_HOLD; returns at the start of RUN cycle 0.
  task automatic do_restart();
    wb_en = 1'b0; trace_ready = 1'b0; instr = 32'h0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; restart = 1'b0; pc = '0; instr = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; trace_ready = 1'b0;
    #22;
    checks++; if (state !== 2'b00) $display("FAIL rst_state: got %0h want 0", state); else passed++;
    checks++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset: got %0b want 1", core_reset); else passed++;
    checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0)
      $display("FAIL rst_counters: got %0d/%0d want 0/0", cycle_count, retired_count); else passed++;
    checks++; if (trace_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rst_fifo: got valid=%0b ovf=%0b want 0/0", trace_valid, overflow); else passed++;
    reset_n = 1'b1;
    tick();
    checks++; if (state !== 2'b00 || core_reset !== 1'b1)
      $display("FAIL hold_edge1: got state=%0h core_reset=%0b want 0/1", state, core_reset); else passed++;
    tick();
    checks++; if (state !== 2'b01 || core_reset !== 1'b0)
      $display("FAIL hold_edge2: got state=%0h core_reset=%0b want 1/0", state, core_reset); else passed++;
    checks++; if (cycle_count !== 32'd0) $display("FAIL run_start_count: got %0d want 0", cycle_count); else passed++;
    pc = 64'd0; tick();
    pc = 64'd4; tick();
    checks++; if (cycle_count !== 32'd2 || retired_count !== 32'd1)
      $display("FAIL run_counting: got %0d/%0d want 2/1", cycle_count, retired_count); else passed++;
  endtask

  task automatic test_pc_halt();
    logic [63:0] pcs [7];
    pcs = '{64'd0, 64'd4, 64'd8, 64'd8, 64'd8, 64'd8, 64'd8};
    do_restart();
    for (int i = 0; i < 7; i++) begin
      pc = pcs[i];
      tick();
      if (i == 5) begin
        checks++; if (state !== 2'b01) $display("FAIL stall_not_yet: got %0h want 1", state); else passed++;
      end
    end
    checks++; if (state !== 2'b10 || core_reset !== 1'b1)
      $display("FAIL stall_halt: got state=%0h core_reset=%0b want 2/1", state, core_reset); else passed++;
    checks++; if (retired_count !== 32'd2) $display("FAIL stall_retired: got %0d want 2", retired_count); else passed++;
    checks++; if (cycle_count !== 32'd6) $display("FAIL stall_cycles: got %0d want 6", cycle_count); else passed++;
    pc = 64'd100; tick(); tick();
    checks++; if (state !== 2'b10 || cycle_count !== 32'd6 || retired_count !== 32'd2)
      $display("FAIL halted_frozen: got state=%0h cyc=%0d ret=%0d want 2/6/2", state, cycle_count, retired_count); else passed++;
  endtask

  task automatic test_ecall();
    do_restart();
    for (int i = 0; i < 5; i++) begin
      pc = 64'(4 * i);
      tick();
    end
    pc = 64'd20; instr = 32'h0000_0073;
    checks++; if (state !== 2'b01 || cycle_count !== 32'd5)
      $display("FAIL ecall_pre: got state=%0h cyc=%0d want 1/5", state, cycle_count); else passed++;
    tick();
    instr = 32'h0;
    checks++; if (state !== 2'b10 || core_reset !== 1'b1)
      $display("FAIL ecall_halt: got state=%0h core_reset=%0b want 2/1", state, core_reset); else passed++;
    checks++; if (cycle_count !== 32'd5 || retired_count !== 32'd5)
      $display("FAIL ecall_counts: got %0d/%0d want 5/5", cycle_count, retired_count); else passed++;
    tick();
    checks++; if (cycle_count !== 32'd5) $display("FAIL ecall_frozen: got %0d want 5", cycle_count); else passed++;
  endtask

  task automatic test_timeout();
    do_restart();
    for (int i = 0; i < 20; i++) begin
      pc = 64'(4 * i);
      tick();
      if (i == 18) begin
        checks++; if (state !== 2'b01 || cycle_count !== 32'd19)
          $display("FAIL timeout_pre: got state=%0h cyc=%0d want 1/19", state, cycle_count); else passed++;
      end
    end
    checks++; if (state !== 2'b11 || core_reset !== 1'b1)
      $display("FAIL timeout_state: got state=%0h core_reset=%0b want 3/1", state, core_reset); else passed++;
    checks++; if (cycle_count !== 32'd19 || retired_count !== 32'd19)
      $display("FAIL timeout_counts: got %0d/%0d want 19/19", cycle_count, retired_count); else passed++;
  endtask

  task automatic test_overflow();
    do_restart();
    for (int i = 1; i <= 10; i++) begin
      pc = 64'(4 * i); wb_en = 1'b1; wb_rd = 5'(i); wb_data = 64'(i * 16); trace_ready = 1'b0;
      tick();
      if (i == 1) begin
        checks++; if (trace_valid !== 1'b1) $display("FAIL first_push_valid: got %0b want 1", trace_valid); else passed++;
      end
      if (i == 8) begin
        checks++; if (overflow !== 1'b0) $display("FAIL full_no_ovf: got %0b want 0", overflow); else passed++;
      end
    end
    wb_en = 1'b0;
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_set: got %0b want 1", overflow); else passed++;
    trace_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (trace_valid !== 1'b1 || trace_rd !== 5'(k) || trace_data !== 64'(k * 16))
        $display("FAIL drain_%0d: got v=%0b rd=%0d data=%0h want 1/%0d/%0h",
                 k, trace_valid, trace_rd, trace_data, k, k * 16); else passed++;
      tick();
    end
    trace_ready = 1'b0;
    checks++; if (trace_valid !== 1'b0) $display("FAIL drain_empty: got %0b want 0", trace_valid); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %0b want 1", overflow); else passed++;
  endtask

  task automatic test_full_push_pop();
    do_restart();
    checks++; if (overflow !== 1'b0) $display("FAIL restart_clears_ovf: got %0b want 0", overflow); else passed++;
    for (int i = 1; i <= 8; i++) begin
      pc = 64'(4 * i); wb_en = 1'b1; wb_rd = 5'(i); wb_data = 64'(i * 16); trace_ready = 1'b0;
      tick();
    end
    pc = 64'd36; wb_rd = 5'd9; wb_data = 64'h90; trace_ready = 1'b1;
    checks++; if (trace_rd !== 5'd1) $display("FAIL full_head: got %0d want 1", trace_rd); else passed++;
    tick();
    wb_en = 1'b0; trace_ready = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL pushpop_no_ovf: got %0b want 0", overflow); else passed++;
    trace_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      checks++; if (trace_valid !== 1'b1 || trace_rd !== 5'(k) || trace_data !== 64'(k * 16))
        $display("FAIL pushpop_drain_%0d: got v=%0b rd=%0d data=%0h want 1/%0d/%0h",
                 k, trace_valid, trace_rd, trace_data, k, k * 16); else passed++;
      tick();
    end
    trace_ready = 1'b0;
    checks++; if (trace_valid !== 1'b0) $display("FAIL pushpop_empty: got %0b want 0", trace_valid); else passed++;
  endtask

  task automatic test_restart_mid_run();
    do_restart();
    pc = 64'd4; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hdead;
    tick();
    checks++; if (trace_valid !== 1'b0) $display("FAIL rd0_ignored: got %0b want 0", trace_valid); else passed++;
    for (int i = 1; i <= 3; i++) begin
      pc = 64'(4 + 4 * i); wb_rd = 5'(i); wb_data = 64'(i * 16);
      tick();
    end
    checks++; if (trace_valid !== 1'b1 || state !== 2'b01 || cycle_count !== 32'd4)
      $display("FAIL pre_restart: got v=%0b state=%0h cyc=%0d want 1/1/4", trace_valid, state, cycle_count); else passed++;
    restart = 1'b1; instr = 32'h0000_0073; pc = 64'd100;
    tick();
    restart = 1'b0; instr = 32'h0;
    checks++; if (state !== 2'b00 || core_reset !== 1'b1)
      $display("FAIL restart_state: got state=%0h core_reset=%0b want 0/1", state, core_reset); else passed++;
    checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0)
      $display("FAIL restart_counters: got %0d/%0d want 0/0", cycle_count, retired_count); else passed++;
    checks++; if (trace_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL restart_fifo: got v=%0b ovf=%0b want 0/0", trace_valid, overflow); else passed++;
    tick();
    wb_en = 1'b0;
    checks++; if (trace_valid !== 1'b0) $display("FAIL hold_push_ignored: got %0b want 0", trace_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_pc_halt();
    test_ecall();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_restart_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
